// File: rtl/rx_pkg.sv
// rx_pkg: shared receive-path definitions for serial_to_parallel and
// byte_unstripping.
//   COM      - comma/idle symbol that byte alignment locks on
//   PAD      - pad/idle filler symbol used further down the receive path
//   rx_state_e - deserializer alignment FSM encoding
package rx_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: one-lane receive deserializer. Shifts in one serial bit
// per clk_32f edge (MSB first), finds byte alignment on the COM symbol and,
// after COM_LOCK consecutive aligned COMs, delivers bytes.
//
// Ports:
//   clk_32f   - bit clock, one serial bit per rising edge
//   reset     - asynchronous, active-high
//   data_in   - serial bit
//   data_out  - last deserialized byte (holds between boundaries)
//   valid_out - data_out is a non-COM byte received while ACTIVE
//   byte_stb  - one-cycle pulse on each byte boundary while ACTIVE
//   active    - lane aligned and locked (sticky until reset)
//   state     - alignment FSM state, exposed for debug/checkers
//
// Output semantics: there is no back-pressure. byte_stb marks the single
// cycle in which a new byte appears on data_out; valid_out qualifies that
// byte (and the following 7 cycles it is held) as payload rather than COM.
module serial_to_parallel #(
  parameter logic [7:0]  COM      = rx_pkg::COM,
  parameter int unsigned COM_LOCK = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active,
  output logic [1:0] state
);

  import rx_pkg::*;

  localparam logic [3:0] LOCK_CNT = COM_LOCK[3:0];

  rx_state_e  state_q;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [7:0] cand;
  logic       boundary;

  // The byte ending with the bit being sampled right now.
  assign cand     = {sr[6:0], data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign state    = state_q;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      com_cnt   <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= cand;
      case (state_q)
        SEARCH: begin
          // Sliding window: any bit position may start a byte.
          if (cand == COM) begin
            bit_cnt <= 3'd0;
            if (COM_LOCK == 1) begin
              state_q <= ACTIVE;
            end else begin
              com_cnt <= 4'd1;
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (cand == COM) begin
              com_cnt <= com_cnt + 4'd1;
              if (com_cnt + 4'd1 == LOCK_CNT) begin
                state_q <= ACTIVE;
              end
            end else begin
              com_cnt <= 4'd0;
              state_q <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // active follows the state one edge later, so it rises on the
          // edge after the locking COM completes.
          active  <= 1'b1;
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_out  <= cand;
            valid_out <= (cand != COM);
            byte_stb  <= 1'b1;
          end else begin
            byte_stb  <= 1'b0;
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

endmodule
